// File: rtl/prog_clk_divider.sv
// prog_clk_divider: programmable clock divider with registered outClk/tick.
// The divisor N and high-time H are reconfigurable through a pending register
// that takes effect only at a period boundary, so no period mixes old and new
// settings.
// Build option: define CLKDIV_DUTY_EN to make H programmable via cfg_high /
// DEFAULT_HIGH. Without it, cfg_high is ignored and H = N >> 1.
module prog_clk_divider #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEFAULT_DIV  = 4,
    parameter int unsigned DEFAULT_HIGH = 2
) (
    input  logic             inClk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_busy,
    output logic             outClk,
    output logic             tick
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_HIGH);

    // Period counter and registered outputs
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             outclk_q, outclk_d;
    logic             tick_q, tick_d;

    // Active and pending configuration
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] high_act;

`ifdef CLKDIV_DUTY_EN
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] phigh_q, phigh_d;

    assign high_act = high_q;
`else
    // cfg_high and DEFAULT_HIGH have no function in this build.
    logic unused_high;

    assign unused_high = ^{cfg_high, RST_HIGH};
    assign high_act    = div_q >> 1;
`endif

    // Control decode
    logic running;   // enabled with a non-zero divisor
    logic at_end;    // this edge closes the current period
    logic apply;     // pending configuration becomes active on this edge

    assign running = en && (div_q != '0);
    // ">=" rather than "==" so an out-of-range count wraps on the next edge.
    assign at_end  = running && (cnt_q >= (div_q - ONE));
    // A load on the same edge supersedes whatever was pending, so it blocks
    // the apply; the fresh value waits for the next boundary.
    assign apply   = busy_q && !cfg_load && (at_end || !running);

    // Next counter value and registered outClk/tick, using the pre-edge count
    always_comb begin
        cnt_d    = '0;
        outclk_d = 1'b0;
        tick_d   = 1'b0;
        if (running) begin
            cnt_d    = at_end ? '0 : (cnt_q + ONE);
            outclk_d = (cnt_q < high_act);
            tick_d   = at_end;
        end
    end

    // Next configuration: capture loads as pending, promote at a boundary
    always_comb begin
        div_d   = div_q;
        pdiv_d  = pdiv_q;
        busy_d  = busy_q;
`ifdef CLKDIV_DUTY_EN
        high_d  = high_q;
        phigh_d = phigh_q;
`endif
        if (cfg_load) begin
            pdiv_d  = cfg_div;
`ifdef CLKDIV_DUTY_EN
            phigh_d = cfg_high;
`endif
            busy_d  = 1'b1;
        end else if (apply) begin
            div_d   = pdiv_q;
`ifdef CLKDIV_DUTY_EN
            high_d  = phigh_q;
`endif
            busy_d  = 1'b0;
        end
    end

    // State registers with synchronous reset having priority over everything
    always_ff @(posedge inClk) begin
        if (reset) begin
            cnt_q    <= '0;
            outclk_q <= 1'b0;
            tick_q   <= 1'b0;
            div_q    <= RST_DIV;
            pdiv_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            outclk_q <= outclk_d;
            tick_q   <= tick_d;
            div_q    <= div_d;
            pdiv_q   <= pdiv_d;
            busy_q   <= busy_d;
        end
    end

`ifdef CLKDIV_DUTY_EN
    // High-time registers, reset alongside the divisor
    always_ff @(posedge inClk) begin
        if (reset) begin
            high_q  <= RST_HIGH;
            phigh_q <= '0;
        end else begin
            high_q  <= high_d;
            phigh_q <= phigh_d;
        end
    end
`endif

    assign outClk   = outclk_q;
    assign tick     = tick_q;
    assign cfg_busy = busy_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed scoreboard bench for prog_clk_divider.
// The driver pushes the expected post-edge outClk/tick/cfg_busy for every
// cycle it drives; the monitor pops and compares on the falling edge.
module tb_prog_clk_divider;

    localparam int unsigned W = 16;

    logic         clk;
    logic         reset;
    logic         en;
    logic         cfg_load;
    logic [W-1:0] cfg_div;
    logic [W-1:0] cfg_high;
    logic         cfg_busy;
    logic         outClk;
    logic         tick;

    prog_clk_divider #(
        .WIDTH       (W),
        .DEFAULT_DIV (4),
        .DEFAULT_HIGH(2)
    ) dut (
        .inClk   (clk),
        .reset   (reset),
        .en      (en),
        .cfg_load(cfg_load),
        .cfg_div (cfg_div),
        .cfg_high(cfg_high),
        .cfg_busy(cfg_busy),
        .outClk  (outClk),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        o;
        logic        t;
        logic        b;
        int unsigned id;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int unsigned ncyc  = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic chk(input string nm, input int unsigned id, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b, expected %b", nm, id, act, exp);
        end
    endtask

    // Monitor: one expected entry per driven edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk("outClk",   cur.id, outClk,   cur.o);
            chk("tick",     cur.id, tick,     cur.t);
            chk("cfg_busy", cur.id, cfg_busy, cur.b);
        end
    end

    // Expected high-time for a given load in this build
    function automatic int eh(input int dv, input int hi);
`ifdef CLKDIV_DUTY_EN
        return hi;
`else
        return (hi >= 0) ? dv / 2 : 0;
`endif
    endfunction

    task automatic cyc(input bit e, input bit ld, input int dv, input int hi,
                       input bit xo, input bit xt, input bit xb);
        reset    = 1'b0;
        en       = e;
        cfg_load = ld;
        cfg_div  = W'(dv);
        cfg_high = W'(hi);
        sb.push_back('{o: xo, t: xt, b: xb, id: ncyc});
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    // Reset cycle with en and cfg_load also asserted: reset must win
    task automatic rst_cyc();
        reset    = 1'b1;
        en       = 1'b1;
        cfg_load = 1'b1;
        cfg_div  = W'(9);
        cfg_high = W'(9);
        sb.push_back('{o: 1'b0, t: 1'b0, b: 1'b0, id: ncyc});
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    // Cycle i of a period with active N=n, H=h
    task automatic pc(input int n, input int h, input int i, input bit ld,
                      input int dv, input int hi, input bit xb);
        cyc(1'b1, ld, dv, hi, i < h, i == n - 1, xb);
    endtask

    task automatic period(input int n, input int h, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++)
                pc(n, h, i, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int k, input bit xb);
        for (int j = 0; j < k; j++)
            cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, xb);
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        cfg_load = 1'b0;
        cfg_div  = '0;
        cfg_high = '0;

        // Reset state, then defaults N=4/H=2: 1,1,0,0 with tick on 4th
        rst_cyc();
        rst_cyc();
        period(4, 2, 3);

        // Mid-period load div=5 high=1: current period finishes at N=4
        pc(4, 2, 0, 1'b0, 0, 0, 1'b0);
        pc(4, 2, 1, 1'b1, 5, 1, 1'b1);
        pc(4, 2, 2, 1'b0, 0, 0, 1'b1);
        pc(4, 2, 3, 1'b0, 0, 0, 1'b0);
        period(5, eh(5, 1), 2);

        // div=0 turns the divider off at the boundary
        pc(5, eh(5, 1), 0, 1'b1, 0, 0, 1'b1);
        for (int i = 1; i < 4; i++) pc(5, eh(5, 1), i, 1'b0, 0, 0, 1'b1);
        pc(5, eh(5, 1), 4, 1'b0, 0, 0, 1'b0);
        for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Load while N=0 applies on the next edge; then N=1 ticks every cycle
        cyc(1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 0, 0, eh(1, 1) > 0, 1'b1, 1'b0);

        // Load on a boundary edge is held until the following boundary
        cyc(1'b1, 1'b1, 4, 0, eh(1, 1) > 0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 0, 0, eh(1, 1) > 0, 1'b1, 1'b0);
        period(4, eh(4, 0), 2);

        // high=9 with div=6
        pc(4, eh(4, 0), 0, 1'b1, 6, 9, 1'b1);
        pc(4, eh(4, 0), 1, 1'b0, 0, 0, 1'b1);
        pc(4, eh(4, 0), 2, 1'b0, 0, 0, 1'b1);
        pc(4, eh(4, 0), 3, 1'b0, 0, 0, 1'b0);
        period(6, eh(6, 9), 2);

        // Two loads before one boundary: only div=7 survives
        pc(6, eh(6, 9), 0, 1'b1, 3, 1, 1'b1);
        pc(6, eh(6, 9), 1, 1'b1, 7, 2, 1'b1);
        for (int i = 2; i < 5; i++) pc(6, eh(6, 9), i, 1'b0, 0, 0, 1'b1);
        pc(6, eh(6, 9), 5, 1'b0, 0, 0, 1'b0);
        period(7, eh(7, 2), 2);

        // div=7 high=6: 3 high / 4 low unless the duty option is built in
        pc(7, eh(7, 2), 0, 1'b1, 7, 6, 1'b1);
        for (int i = 1; i < 6; i++) pc(7, eh(7, 2), i, 1'b0, 0, 0, 1'b1);
        pc(7, eh(7, 2), 6, 1'b0, 0, 0, 1'b0);
        period(7, eh(7, 6), 2);

        // en low for 10 cycles mid-period; a load while disabled applies next edge
        for (int i = 0; i < 3; i++) pc(7, eh(7, 6), i, 1'b0, 0, 0, 1'b0);
        idle(5, 1'b0);
        cyc(1'b0, 1'b1, 4, 2, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0);
        period(4, eh(4, 2), 1);

        // Reset mid-period with a pending load: defaults back, load lost
        pc(4, eh(4, 2), 0, 1'b0, 0, 0, 1'b0);
        pc(4, eh(4, 2), 1, 1'b1, 5, 1, 1'b1);
        rst_cyc();
        period(4, 2, 2);

        en       = 1'b0;
        cfg_load = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter WIDTH, default 16: width of the divisor, high-time and internal counter.
REQ-002 Parameter DEFAULT_DIV, default 4: active divisor N after reset.
REQ-003 Parameter DEFAULT_HIGH, default 2: active high-time H after reset.
REQ-004 Port inClk, input, 1: sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port en, input, 1: count enable.
REQ-007 Port cfg_load, input, 1: single-cycle request to load a new configuration.
REQ-008 Port cfg_div, input, WIDTH: requested divisor, sampled when cfg_load=1.
REQ-009 Port cfg_high, input, WIDTH: requested high-time, sampled when cfg_load=1.
REQ-010 Port cfg_busy, output, 1: high while a loaded configuration is pending and not yet active.
REQ-011 Port outClk, output, 1: divided clock, registered.
REQ-012 Port tick, output, 1: one-cycle end-of-period strobe, registered.

Function
REQ-013 Counter cnt SHALL be WIDTH bits; on each edge with en=1 and N>=1: cnt <= (cnt >= N-1) ? 0 : cnt+1.
REQ-014 outClk SHALL be registered as (cnt < H) using the pre-edge cnt, giving one inClk cycle of latency from cnt to outClk.
REQ-015 tick SHALL be registered as (cnt >= N-1) and SHALL be high for exactly one inClk cycle per period.
REQ-016 outClk period SHALL be exactly N inClk cycles, with H high cycles followed by N-H low cycles.
REQ-017 If H=0, outClk SHALL stay 0. If H>=N, outClk SHALL stay 1. tick SHALL be unaffected in both cases.
REQ-018 If N=1, outClk SHALL stay 1 when H>=1, and tick SHALL be 1 on every enabled cycle.
REQ-019 If N=0, the divider is off: cnt is held at 0, and outClk and tick are driven 0 on the next edge.
REQ-020 With en=0: cnt <= 0, outClk <= 0, tick <= 0. When en returns to 1, a new period starts from cnt=0.
REQ-021 cfg_load=1 SHALL capture cfg_div and cfg_high into pending registers and set cfg_busy on the next edge.
REQ-022 The pending configuration SHALL become active at the edge where cnt >= N-1 (period boundary), so the new period runs entirely with new N/H; cfg_busy SHALL clear on that same edge.
REQ-023 If en=0 or active N=0 when a pending configuration exists, it SHALL be applied on the next edge.
REQ-024 cfg_load while cfg_busy=1 SHALL overwrite the pending values; only the last load is applied.
REQ-025 cfg_load on the same edge as the period boundary SHALL be captured as pending and applied at the following boundary. The previous pending value, if any, is discarded.
REQ-026 cnt >= N (possible only transiently) SHALL wrap to 0 on the next enabled edge, with no glitch beyond one short period.

Reset
REQ-027 On reset=1 at an edge: cnt=0, outClk=0, tick=0, cfg_busy=0, pending cleared, N=DEFAULT_DIV, H=DEFAULT_HIGH.
REQ-028 reset SHALL take priority over en and cfg_load; asserting it mid-period SHALL abort the period and discard any pending load.

Configuration
REQ-029 Macro CLKDIV_DUTY_EN defined: H SHALL come from DEFAULT_HIGH or cfg_high as specified above.
REQ-030 Macro CLKDIV_DUTY_EN undefined: cfg_high SHALL be ignored and H SHALL equal N>>1 (50% duty for even N, low-biased for odd N, e.g. N=3 gives 1 high / 2 low). All other behaviour is unchanged.

Verification
REQ-031 Reset released, en=1, defaults N=4/H=2 -> outClk 1,1,0,0 repeating from the first post-reset edge; tick on every 4th cycle, coincident with the 4th cycle of each period.
REQ-032 cfg_load with div=5, high=1 mid-period -> cfg_busy=1 until the boundary; the current period completes at N=4, then the next period is 1 high / 4 low; cfg_busy clears at the boundary.
REQ-033 Boundary cases: div=0 -> outClk=0, tick=0; div=1, high=1 -> outClk constant 1, tick every cycle; high=0 -> outClk=0; high=9 with div=6 -> outClk=1, tick period 6.
REQ-034 Two cfg_load pulses (div=3 then div=7) before one boundary -> only div=7 is applied; period measured as 7.
REQ-035 en dropped for 10 cycles mid-period, then raised -> outClk=0 and tick=0 while low; the first new period is full length from cnt=0. Repeat with reset pulsed mid-period -> defaults are restored and the pending load is lost.
REQ-036 Build without CLKDIV_DUTY_EN, div=7, high=6 -> outClk 3 high / 4 low.
